// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, adder selects and FSM state encodings for the iterative
// multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Divide ops share op[1]=1; multiply ops have op[1]=0.
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_adder.sv
// ALU adder slice: add or subtract of two OPERAND_LENGTH-bit values,
// unsigned modulo 2^OPERAND_LENGTH.
module muldiv_sequencer_adder
    import muldiv_sequencer_pkg::*;
#(
    parameter int OPERAND_LENGTH = 33
) (
    input  logic [3:0]                alu_op,
    input  logic [OPERAND_LENGTH-1:0] opd_a,
    input  logic [OPERAND_LENGTH-1:0] opd_b,
    output logic [OPERAND_LENGTH-1:0] result
);

    always_comb begin
        if (alu_op == ALU_SUB) result = opd_a - opd_b;
        else                   result = opd_a + opd_b;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: one N+1 bit adder stepped over
// N cycles (shift-add multiply, restoring shift-subtract divide).
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int OPERAND_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [OPERAND_LENGTH-1:0] req_opd1,
    input  logic [OPERAND_LENGTH-1:0] req_opd2,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [OPERAND_LENGTH-1:0] resp_result,
    output logic                      busy
);

    localparam int N  = OPERAND_LENGTH;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t        state, state_next;
    logic [1:0]    op_q;
    logic [CW-1:0] count;
    // acc is hi (multiply) or rem (divide); sr is lo or quo; opb is mcand or dvsr.
    logic [N:0]    acc;
    logic [N-1:0]  sr;
    logic [N-1:0]  opb;

    logic [N:0]    add_a, add_b, sum;
    logic [3:0]    add_sel;
    logic          accept;

    assign accept = req_valid && !flush;

    always_comb begin
        if (is_div(op_q)) begin
            add_a   = {acc[N-1:0], sr[N-1]};
            add_b   = {1'b0, opb};
            add_sel = ALU_SUB;
        end else begin
            add_a   = {1'b0, acc[N-1:0]};
            add_b   = sr[0] ? {1'b0, opb} : '0;
            add_sel = ALU_ADD;
        end
    end

    muldiv_sequencer_adder #(.OPERAND_LENGTH(N + 1)) u_adder (
        .alu_op (add_sel),
        .opd_a  (add_a),
        .opd_b  (add_b),
        .result (sum)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (req_valid) state_next = S_RUN;
                S_RUN:   if (count == CW'(N - 1)) state_next = S_DONE;
                S_DONE:  if (resp_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            count <= '0;
            acc   <= '0;
            sr    <= '0;
            opb   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && accept) begin
                op_q  <= req_op;
                count <= '0;
                acc   <= '0;
                sr    <= is_div(req_op) ? req_opd1 : req_opd2;
                opb   <= is_div(req_op) ? req_opd2 : req_opd1;
            end else if (state == S_RUN && !flush) begin
                count <= count + CW'(1);
                if (is_div(op_q)) begin
                    // Restore on borrow: keep the shifted remainder, quotient bit 0.
                    acc <= sum[N] ? add_a : sum;
                    sr  <= {sr[N-2:0], ~sum[N]};
                end else begin
                    acc <= {1'b0, sum[N:1]};
                    sr  <= {sum[0], sr[N-1:1]};
                end
            end
        end
    end

    // MUL/DIVU take the shift register, MULHU/REMU take the accumulator.
    assign resp_result = op_q[0] ? acc[N-1:0] : sr;
    assign req_ready   = (state == S_IDLE);
    assign resp_valid  = (state == S_DONE);
    assign busy        = (state == S_RUN) || (state == S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table, backpressure, flush and reset
// corner sequences, plus random operations against a reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [1:0]   req_op;
    logic [N-1:0] req_opd1, req_opd2, resp_result;

    logic [N-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    muldiv_sequencer #(.OPERAND_LENGTH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_opd1    (req_opd1),
        .req_opd2    (req_opd2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (op)
            MD_MUL:   return p[N-1:0];
            MD_MULHU: return p[2*N-1:N];
            MD_DIVU:  return (b == 0) ? {N{1'b1}} : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present one request; the accepting edge is the edge this task steps over.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] e, input bit push);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("issue_ready", {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_opd1  = a;
        req_opd2  = b;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_opd1  = $urandom;
        req_opd2  = $urandom;
    endtask

    task automatic wait_resp();
        int n = 0;
        bit leaked = 1'b0;
        while (!resp_valid && n < N + 20) begin
            if (req_ready || !busy) leaked = 1'b1;
            @(negedge clk);
            n++;
        end
        check("latency", n, N);
        check("ready_low_in_run", {31'b0, leaked}, 0);
    endtask

    task automatic take_resp(input string name);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got response %h expected none queued", name, resp_result);
        end else begin
            e = exp_q.pop_front();
            check(name, resp_result, e);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_done", {29'b0, req_ready, resp_valid, busy}, 3'b100);
    endtask

    initial begin
        logic [N-1:0] r0, a, b;
        logic [1:0]   op;
        bit           ok, saw;

        vecs[0]  = '{MD_MUL,   32'd6,          32'd7,          32'h0000002A};
        vecs[1]  = '{MD_MUL,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000002};
        vecs[2]  = '{MD_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'hFFFFFFFD};
        vecs[3]  = '{MD_MULHU, 32'h00010000,   32'h00010000,   32'h00000001};
        vecs[4]  = '{MD_DIVU,  32'd100,        32'd7,          32'd14};
        vecs[5]  = '{MD_REMU,  32'd100,        32'd7,          32'd2};
        vecs[6]  = '{MD_DIVU,  32'h12345678,   32'd0,          32'hFFFFFFFF};
        vecs[7]  = '{MD_REMU,  32'h12345678,   32'd0,          32'h12345678};
        vecs[8]  = '{MD_DIVU,  32'd5,          32'd9,          32'd0};
        vecs[9]  = '{MD_REMU,  32'd5,          32'd9,          32'd5};
        vecs[10] = '{MD_DIVU,  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_opd1 = '0; req_opd2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_flags", {29'b0, req_ready, resp_valid, busy}, 3'b100);
        check("reset_result", resp_result, '0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_resp();
            take_resp($sformatf("vec%0d", i));
        end

        // Backpressure: result and valid held, new request ignored.
        issue(MD_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_resp();
        r0 = resp_result;
        ok = 1'b1;
        req_valid = 1'b1; req_op = MD_MUL; req_opd1 = 32'd2; req_opd2 = 32'd2;
        repeat (5) begin
            @(negedge clk);
            if (resp_result !== r0 || !resp_valid || req_ready) ok = 1'b0;
        end
        req_valid = 1'b0;
        check("backpressure_hold", {31'b0, ok}, 1);
        take_resp("backpressure_result");
        @(negedge clk);
        check("backpressure_no_accept", {29'b0, req_ready, resp_valid, busy}, 3'b100);

        // Flush mid-divide: back to idle, no response.
        issue(MD_DIVU, 32'h12345678, 32'd3, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {29'b0, req_ready, resp_valid, busy}, 3'b100);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        check("flush_no_resp", {31'b0, saw}, 0);
        issue(MD_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
        wait_resp();
        take_resp("mul_after_flush");

        // Flush with a request in idle: not accepted.
        req_valid = 1'b1; flush = 1'b1; req_op = MD_MUL; req_opd1 = 32'd5; req_opd2 = 32'd5;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {29'b0, req_ready, resp_valid, busy}, 3'b100);
        @(negedge clk);
        check("flush_blocks_accept_2", {29'b0, req_ready, resp_valid, busy}, 3'b100);

        // Reset mid-run discards the operation.
        issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_reset_flags", {29'b0, req_ready, resp_valid, busy}, 3'b100);
        check("midrun_reset_result", resp_result, '0);
        issue(MD_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
        wait_resp();
        take_resp("divu_after_reset");

        // Random operations against the reference model.
        for (int k = 0; k < 8; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (k == 3) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 255)) : $urandom;
            issue(op, a, b, model(op, a, b), 1'b1);
            wait_resp();
            take_resp($sformatf("rand%0d", k));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative unsigned multiply/divide unit for the RV32M subset MUL, MULHU, DIVU and REMU.
- Sequences one shared ALU adder instance over OPERAND_LENGTH cycles: shift-add for multiply, restoring shift-subtract for divide.
- Sits beside the ALU in the execute stage.
- Uses a valid/ready request/response handshake and a flush input for pipeline kills.

Parameters:
- OPERAND_LENGTH, 32: operand and result width N. Must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  cancels any in-flight or pending operation.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high exactly in IDLE.
- req_op  input  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
- req_opd1  input  N  multiplicand or dividend.
- req_opd2  input  N  multiplier or divisor.
- resp_valid  output  1  result available; high exactly in DONE.
- resp_ready  input  1  consumer takes the result.
- resp_result  output  N  result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: on a clk edge with rst=1, state goes to IDLE and all registers are cleared. After reset: req_ready=1, resp_valid=0, busy=0, resp_result=0.
- States and transitions:
  - IDLE: on req_valid && !flush, latch op and operands; clear counter; go to RUN.
  - RUN: perform one iteration per cycle. When count==N-1, do the final iteration and go to DONE.
  - DONE: hold resp_result stable. On resp_ready, go to IDLE.
- flush: in any state, go to IDLE on the next edge. No response is produced. In IDLE, flush has priority over req_valid, so the request is not accepted.
- rst has priority over flush and over everything else. Reset mid-operation discards the operation.
- Latency: with the accepting edge as edge 0, resp_valid rises after edge N (32 cycles at default).
- Throughput: at least one bubble between operations. Completion (DONE with resp_ready) and a new acceptance never occur on the same edge.
- Backpressure: resp_result and resp_valid are held indefinitely while resp_ready=0.
- Multiply datapath:
  - Registers: hi (N bits, cleared), lo = opd2, mcand = opd1.
  - Each iteration: sum = {0,hi} + (lo[0] ? {0,mcand} : 0), an (N+1)-bit add with ALU op select 0000. Then {hi,lo} = {sum, lo[N-1:1]}, i.e. a right shift through the carry.
  - After N iterations, {hi,lo} holds the full 2N-bit product.
  - MUL returns lo; MULHU returns hi.
- Divide datapath:
  - Registers: rem (N+1 bits, cleared), quo = opd1, dvsr = opd2.
  - Each iteration: sh = {rem[N-1:0], quo[N-1]}; diff = sh − {0,dvsr}, using ALU op select 1000.
    - If diff[N]==0: rem = diff, quo = {quo[N-2:0],1}.
    - Else: rem = sh, quo = {quo[N-2:0],0}.
  - DIVU returns quo; REMU returns rem[N-1:0].
- Divide by zero needs no special case. The algorithm inherently yields quo = all ones and rem = dividend, matching the RISC-V spec. Latency is unchanged.
- Adder instance: one adder of width N+1 feeds both datapaths. Its operands and op select are muxed by the latched op class (multiply vs divide). All arithmetic is unsigned modulo 2^(N+1).
- Operand registers are not touched outside IDLE acceptance. Input changes during RUN have no effect.

Decomposition:
- Shared header muldiv_defs.vh holds:
  - op codes MD_MUL=2'b00, MD_MULHU=2'b01, MD_DIVU=2'b10, MD_REMU=2'b11;
  - adder selects ALU_ADD=4'b0000 and ALU_SUB=4'b1000;
  - state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module: the existing adder, instantiated once with OPERAND_LENGTH=N+1. No other sub-modules.

Test Plan:
- MUL 6×7, then MUL 0xFFFFFFFF×0xFFFFFFFE -> 0x0000002A, then 0x00000002. Each result has resp_valid high exactly 32 cycles after acceptance, and req_ready=0 throughout.
- MULHU 0xFFFFFFFF×0xFFFFFFFE -> 0xFFFFFFFD. MULHU 0x00010000×0x00010000 -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678. DIVU 5/9 -> 0; REMU 5/9 -> 5.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> resp_result is stable and req_valid is ignored. Then pulse resp_ready -> IDLE next cycle, and req_ready=1 one cycle after completion.
- Flush: assert flush 10 cycles into a DIVU -> IDLE next edge, no resp_valid. Then MUL 3×4 -> 12. Also flush+req_valid together in IDLE -> the request is not accepted.
- Reset mid-RUN: assert rst at cycle 15 of a MULHU -> req_ready=1, busy=0, resp_valid=0, resp_result=0 after the edge. The next request (DIVU 9/3 -> 3) completes normally.
